// File: rtl/ppacc_seq.sv
// Sequential radix-4 Booth partial-product accumulator: captures one PP set,
// adds one 4^k-weighted term per cycle, then holds the signed product until accepted.
module ppacc_seq #(
  parameter int unsigned PP_W = 9,
  parameter int unsigned N_PP = 4,
  parameter int unsigned P_W  = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_PP*PP_W-1:0] pp,
  input  logic [N_PP-1:0]      sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_W-1:0]       product
);

  localparam int unsigned KW = (N_PP > 1) ? $clog2(N_PP) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_PP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [N_PP*PP_W-1:0]  pp_q, pp_d;
  logic [N_PP-1:0]       sign_q, sign_d;
  logic [P_W-1:0]        acc_q, acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic [P_W-1:0]        prod_q, prod_d;
  logic                  ovalid_q, ovalid_d;

  // Current term selection and weighting
  logic [PP_W-1:0]       pp_sel;
  logic                  sign_sel;
  logic signed [PP_W:0]  term_raw;
  logic signed [P_W-1:0] term_ext;
  logic [P_W-1:0]        term_val;
  logic [P_W-1:0]        term_sh;

  always_comb begin
    pp_sel   = '0;
    sign_sel = 1'b0;
    for (int unsigned i = 0; i < N_PP; i++) begin
      if (k_q == KW'(i)) begin
        pp_sel   = pp_q[i*PP_W +: PP_W];
        sign_sel = sign_q[i];
      end
    end
    // {sign,pp} is the ones'-complement term; adding sign completes the negation
    term_raw = {sign_sel, pp_sel};
    term_ext = P_W'(term_raw);
    term_val = term_ext + P_W'(sign_sel);
    term_sh  = term_val << {k_q, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pp_q     <= '0;
      sign_q   <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      prod_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pp_q     <= pp_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      prod_q   <= prod_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pp_d     = pp_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    k_d      = k_q;
    prod_d   = prod_q;
    ovalid_d = ovalid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pp_d    = pp;
          sign_d  = sign;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + term_sh;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle loads the registered output, so out_valid rises
        // N_PP+1 edges after the accept edge and product is glitch-free.
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
          prod_d   = acc_q;
        end else if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ovalid_q;
  assign product   = prod_q;

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(product)));

endmodule

// File: tb/tb_ppacc_seq.sv
// Directed bench for ppacc_seq: table of Booth PP sets with hand-computed products,
// plus backpressure, input-scrambling and mid-operation reset sequences.
module tb_ppacc_seq;

  localparam int unsigned PP_W = 9;
  localparam int unsigned N_PP = 4;
  localparam int unsigned P_W  = 17;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_PP*PP_W-1:0] pp;
  logic [N_PP-1:0]      sign;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_W-1:0]       product;

  int n_checks;
  int n_errors;

  ppacc_seq #(.PP_W(PP_W), .N_PP(N_PP), .P_W(P_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp        (pp),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][8:0] pp;
    logic [3:0]      sign;
    logic [16:0]     exp;
    int              hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one set: accept, scramble inputs during ACC, check latency, hold, release.
  task automatic run_set(input vec_t v, input int idx);
    int edges;
    @(negedge clk);
    check($sformatf("v%0d in_ready idle", idx), 32'(in_ready), 32'd1);
    pp       = v.pp;
    sign     = v.sign;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d in_ready acc", idx), 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      pp   = {$urandom, $urandom};
      sign = 4'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check($sformatf("v%0d latency", idx), 32'(edges), 32'd5);
    check($sformatf("v%0d product", idx), 32'(product), 32'(v.exp));
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1;
      pp       = {$urandom, $urandom};
      sign     = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d hold out_valid", idx), 32'(out_valid), 32'd1);
      check($sformatf("v%0d hold product", idx), 32'(product), 32'(v.exp));
      check($sformatf("v%0d hold in_ready", idx), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d released out_valid", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d released in_ready", idx), 32'(in_ready), 32'd1);
    check($sformatf("v%0d product kept", idx), 32'(product), 32'(v.exp));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp        = '0;
    sign      = '0;

    // X=3,Y=5: -5 + 5*4 = 15
    vecs[0] = '{pp: {9'h000, 9'h000, 9'h005, 9'h1FA}, sign: 4'b0001, exp: 17'd15,     hold: 0};
    // digit3 = -2, Y=255: -510*64 = -32640
    vecs[1] = '{pp: {9'h001, 9'h000, 9'h000, 9'h000}, sign: 4'b1000, exp: 17'h18080,  hold: 0};
    vecs[2] = '{pp: {9'h000, 9'h000, 9'h000, 9'h000}, sign: 4'b0000, exp: 17'd0,      hold: 0};
    // 510 * 85
    vecs[3] = '{pp: {9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE}, sign: 4'b0000, exp: 17'd43350,  hold: 10};
    // negated zero digits: (-1)+1 each
    vecs[4] = '{pp: {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, sign: 4'b1111, exp: 17'd0,      hold: 0};
    // 3 - 3*4 + 16*16 = 247
    vecs[5] = '{pp: {9'h000, 9'h010, 9'h1FC, 9'h003}, sign: 4'b0010, exp: 17'd247,    hold: 2};
    // -511*85 = -43435 -> 131072-43435
    vecs[6] = '{pp: {9'h000, 9'h000, 9'h000, 9'h000}, sign: 4'b1111, exp: 17'h15655,  hold: 0};
    // -2 only (pp0=~2)
    vecs[7] = '{pp: {9'h000, 9'h000, 9'h000, 9'h1FD}, sign: 4'b0001, exp: 17'h1FFFE,  hold: 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset product", 32'(product), 32'd0);

    // Idle with in_valid low holds state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle hold in_ready", 32'(in_ready), 32'd1);
    check("idle hold out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) run_set(vecs[i], i);

    // Reset mid-ACC at k=2
    @(negedge clk);
    pp       = vecs[0].pp;
    sign     = vecs[0].sign;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst acc in_ready", 32'(in_ready), 32'd1);
    check("rst acc out_valid", 32'(out_valid), 32'd0);
    check("rst acc product", 32'(product), 32'd0);
    // The aborted set must not surface later
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst acc no stale valid", 32'(out_valid), 32'd0);

    // Reset while in DONE with product held
    @(negedge clk);
    pp       = vecs[5].pp;
    sign     = vecs[5].sign;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre-rst done out_valid", 32'(out_valid), 32'd1);
    check("pre-rst done product", 32'(product), 32'd247);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst done in_ready", 32'(in_ready), 32'd1);
    check("rst done out_valid", 32'(out_valid), 32'd0);
    check("rst done product", 32'(product), 32'd0);

    run_set(vecs[1], 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
